// File: rtl/arm_boot_sequencer_if.sv
// Load stream and memory port 2 bundle between the sequencer, the program-word
// source, arm_core's data port and arm_memory.
interface arm_boot_sequencer_if;
    // Load stream: a word moves on a rising edge where ld_valid && ld_ready.
    // The source holds ld_data/ld_last stable while ld_valid is high and
    // ld_ready is low; ld_ready never depends on ld_valid.
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;

    logic [31:0] core_mem_addr;
    logic [31:0] core_mem_data_in;
    logic        core_mem_write_en;

    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_write_en;

    modport master (
        output ld_valid, ld_data, ld_last,
        output core_mem_addr, core_mem_data_in, core_mem_write_en,
        input  ld_ready,
        input  mem_addr, mem_data_in, mem_write_en
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        input  core_mem_addr, core_mem_data_in, core_mem_write_en,
        output ld_ready,
        output mem_addr, mem_data_in, mem_write_en
    );
endinterface

// File: rtl/arm_boot_sequencer.sv
// Boot sequencer: streams a program image into memory port 2 with arm_core held
// in reset, holds reset RST_HOLD more cycles, then hands the port to the core.
module arm_boot_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          RST_HOLD  = 4,
    localparam int         WL_W      = $clog2(MEM_WORDS) + 1,
    localparam int         HOLD_W    = $clog2(RST_HOLD + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      core_rst,
    input  logic                      core_halted,
    arm_boot_sequencer_if.slave       bus,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [WL_W-1:0]           words_loaded,
    output logic [2:0]                dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_HALTED, S_ERROR
    } state_e;

    localparam logic [WL_W-1:0]   WL_MAX    = WL_W'(MEM_WORDS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    state_e              state_q, state_d;
    logic [WL_W-1:0]     wl_q, wl_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                we_q, we_d;
    logic                ld_ready_w;

    assign ld_ready_w = (state_q == S_LOAD) && (wl_q < WL_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wl_q    <= '0;
            hold_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wl_q    <= wl_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wl_d    = wl_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (start) begin
                    state_d = S_LOAD;
                    wl_d    = '0;
                end
            end
            S_LOAD: begin
                if (bus.ld_valid && ld_ready_w) begin
                    addr_d = BASE_ADDR + (32'(wl_q) << 2);
                    data_d = bus.ld_data;
                    we_d   = 1'b1;
                    wl_d   = wl_q + WL_W'(1);
                    if (bus.ld_last) begin
                        state_d = S_RELEASE;
                        hold_d  = '0;
                    end
                end else if (bus.ld_valid) begin
                    // Valid with no room left: the image overflows memory.
                    state_d = S_ERROR;
                end
            end
            S_RELEASE: begin
                // First RELEASE cycle is the one carrying the final write.
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (core_halted) begin
                    state_d = S_HALTED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr     = addr_q;
        bus.mem_data_in  = data_q;
        bus.mem_write_en = we_q;
        case (state_q)
            S_RUN: begin
                bus.mem_addr     = bus.core_mem_addr;
                bus.mem_data_in  = bus.core_mem_data_in;
                bus.mem_write_en = bus.core_mem_write_en;
            end
            S_HALTED: begin
                bus.mem_addr     = bus.core_mem_addr;
                bus.mem_data_in  = bus.core_mem_data_in;
                bus.mem_write_en = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.ld_ready   = ld_ready_w;
    assign core_rst       = !((state_q == S_RUN) || (state_q == S_HALTED));
    assign busy           = (state_q == S_LOAD) || (state_q == S_RELEASE);
    assign done           = (state_q == S_HALTED);
    assign error          = (state_q == S_ERROR);
    assign words_loaded   = wl_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_arm_boot_sequencer.sv
// Bench for arm_boot_sequencer: directed boot scenarios plus random sessions,
// every cycle compared against a phase-level reference model.
module tb_arm_boot_sequencer;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int MW   = 4;
  localparam int RH   = 4;
  localparam int WL_W = $clog2(MW) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_halted = 1'b0;
  logic core_rst, busy, done, error;
  logic [WL_W-1:0] words_loaded;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  arm_boot_sequencer_if bus ();

  arm_boot_sequencer #(.BASE_ADDR(BASE), .MEM_WORDS(MW), .RST_HOLD(RH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .core_rst(core_rst),
    .core_halted(core_halted),
    .bus(bus),
    .busy(busy),
    .done(done),
    .error(error),
    .words_loaded(words_loaded),
    .dbg_state_o(dbg_state)
  );

  // reference model: spec-level phase, word count, release countdown, write queue
  typedef enum {P_IDLE, P_LOAD, P_REL, P_RUN, P_HALT, P_ERR} phase_t;
  phase_t ph;
  int cnt;
  int rel_left;
  bit due;
  logic [63:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE;
    cnt = 0;
    rel_left = 0;
    due = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic [63:0] w;
    check("ld_ready", 64'(bus.ld_ready), 64'(ph == P_LOAD && cnt < MW));
    check("core_rst", 64'(core_rst), 64'(!(ph == P_RUN || ph == P_HALT)));
    check("busy", 64'(busy), 64'(ph == P_LOAD || ph == P_REL));
    check("done", 64'(done), 64'(ph == P_HALT));
    check("error", 64'(error), 64'(ph == P_ERR));
    check("words_loaded", 64'(words_loaded), 64'(cnt));
    if (ph == P_RUN || ph == P_HALT) begin
      check("core_addr_pass", 64'(bus.mem_addr), 64'(bus.core_mem_addr));
      check("core_data_pass", 64'(bus.mem_data_in), 64'(bus.core_mem_data_in));
      check("core_we_pass", 64'(bus.mem_write_en),
            64'((ph == P_RUN) ? bus.core_mem_write_en : 1'b0));
    end else begin
      check("mem_write_en", 64'(bus.mem_write_en), 64'(due));
      if (due && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(w[63:32]));
        check("wr_data", 64'(bus.mem_data_in), 64'(w[31:0]));
      end
    end
  endtask

  task automatic model_step();
    bit nd = 1'b0;
    case (ph)
      P_IDLE, P_HALT, P_ERR: if (start) begin ph = P_LOAD; cnt = 0; end
      P_LOAD: begin
        if (bus.ld_valid && cnt < MW) begin
          exp_q.push_back({BASE + 32'(cnt * 4), bus.ld_data});
          nd = 1'b1;
          cnt++;
          if (bus.ld_last) begin ph = P_REL; rel_left = RH; end
        end else if (bus.ld_valid) begin
          ph = P_ERR;
        end
      end
      P_REL: begin
        rel_left--;
        if (rel_left == 0) ph = P_RUN;
      end
      P_RUN: if (core_halted) ph = P_HALT;
      default: ;
    endcase
    due = nd;
  endtask

  // driver tasks: inputs set at posedge+1, checked at negedge
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    check("rst_core_rst", 64'(core_rst), 64'(1));
    check("rst_ld_ready", 64'(bus.ld_ready), 64'(0));
    check("rst_we", 64'(bus.mem_write_en), 64'(0));
    check("rst_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_data", 64'(bus.mem_data_in), 64'(0));
    check("rst_wl", 64'(words_loaded), 64'(0));
    check("rst_flags", 64'({busy, done, error}), 64'(0));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send_word(input bit v, input bit last, input logic [31:0] d);
    bus.ld_valid = v;
    bus.ld_last = last;
    bus.ld_data = d;
    cycle();
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
  endtask

  task automatic run_phase(input int n, input bit directed);
    for (int i = 0; i < 3 * RH + 4 && ph != P_RUN; i++) begin
      bus.core_mem_addr = $urandom;
      bus.core_mem_data_in = $urandom;
      bus.core_mem_write_en = 1'($urandom_range(0, 1));
      core_halted = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      cycle();
    end
    core_halted = 1'b0;
    start = 1'b0;
    if (directed) begin
      bus.core_mem_addr = 32'h40;
      bus.core_mem_data_in = 32'h1234;
      bus.core_mem_write_en = 1'b1;
      cycle();
    end
    for (int i = 0; i < n; i++) begin
      bus.core_mem_addr = $urandom;
      bus.core_mem_data_in = $urandom;
      bus.core_mem_write_en = 1'($urandom_range(0, 1));
      cycle();
    end
    core_halted = 1'b1;
    cycle();
    core_halted = 1'b0;
    bus.core_mem_write_en = 1'b1;
    cycle();
    bus.core_mem_write_en = 1'b0;
  endtask

  task automatic random_session();
    int n;
    int acc;
    bit ovf;
    bit v;
    ovf = ($urandom_range(0, 4) == 0);
    n = $urandom_range(1, MW);
    acc = 0;
    pulse_start();
    for (int c = 0; c < 40 && ph == P_LOAD; c++) begin
      v = ($urandom_range(0, 99) < 65);
      start = ($urandom_range(0, 9) == 0);
      core_halted = 1'($urandom_range(0, 1));
      bus.core_mem_write_en = 1'($urandom_range(0, 1));
      if (v && cnt < MW) acc++;
      send_word(v, !ovf && v && (acc == n), $urandom);
    end
    start = 1'b0;
    core_halted = 1'b0;
    bus.core_mem_write_en = 1'b0;
    if (ovf) begin
      cycle();
      cycle();
    end else begin
      run_phase($urandom_range(0, 4), 1'b0);
    end
  endtask

  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
    bus.ld_data = '0;
    bus.core_mem_addr = '0;
    bus.core_mem_data_in = '0;
    bus.core_mem_write_en = 1'b0;
    model_reset();
    #2;
    reset_checks();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // four-word image, back to back, then core traffic and halt
    pulse_start();
    send_word(1'b1, 1'b0, 32'hE3A0_0001);
    send_word(1'b1, 1'b0, 32'hE280_0002);
    send_word(1'b1, 1'b0, 32'hE580_0010);
    send_word(1'b1, 1'b1, 32'hEF00_0000);
    run_phase(2, 1'b1);

    // gapped valid on cycles 0,3,4,9
    pulse_start();
    for (int c = 0; c < 10; c++)
      send_word(c == 0 || c == 3 || c == 4 || c == 9, c == 9, $urandom);
    run_phase(1, 1'b0);

    // overflow: five words, no last
    pulse_start();
    for (int c = 0; c < 5; c++) send_word(1'b1, 1'b0, $urandom);
    cycle();
    cycle();
    pulse_start();
    cycle();

    // async reset mid-load after two words
    send_word(1'b1, 1'b0, $urandom);
    send_word(1'b1, 1'b0, $urandom);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // single-word image after the reset
    pulse_start();
    send_word(1'b1, 1'b1, 32'hCAFE_F00D);
    run_phase(1, 1'b0);

    for (int s = 0; s < 30; s++) random_session();

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
